// File: rtl/ob_mk_qty_ctrl.sv
// ob_mk_qty_ctrl
// ---------------------------------------------------------------------------
// Sequencing front-end for the market-order quantity count engine.
// One request at a time is accepted over in_vld/in_rdy. A non-zero request
// issues a one-cycle count command, waits for the engine's busy flag to drop,
// then turns the accumulated book quantity into a fill decision
// (FULL / PARTIAL / REJECT) that is returned over out_vld/out_rdy.
// A zero-quantity request is rejected at once, without an engine command.
//
// Optional build macro OB_MK_QTY_CTRL_TIMEOUT_EN adds a WAIT-state watchdog.
// The watchdog answers with status TIMEOUT (fill 0, remain = request) after
// TIMEOUT_CYCLES busy cycles.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   in_vld/in_rdy        request handshake
//   in_uid, in_quantity  request tag and requested quantity
//   cnt_cmd_vld          single-cycle count command to the engine
//   cnt_busy_w           engine busy; its result is valid on the first low cycle
//   cnt_rsp_quantity_w   engine accumulated quantity (ACC_W bits)
//   out_vld/out_rdy      response handshake
//   out_uid              echoed tag
//   out_status           00 FULL, 01 PARTIAL, 10 REJECT, 11 TIMEOUT
//   out_fill_quantity    quantity fillable
//   out_remain_quantity  requested minus fill
//   busy                 high whenever the controller is not idle
// ---------------------------------------------------------------------------
module ob_mk_qty_ctrl #(
  parameter int QTY_W          = 16,
  parameter int ACC_W          = 20,
  parameter int UID_W          = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [UID_W-1:0] in_uid,
  input  logic [QTY_W-1:0] in_quantity,
  output logic             in_rdy,
  output logic             cnt_cmd_vld,
  input  logic             cnt_busy_w,
  input  logic [ACC_W-1:0] cnt_rsp_quantity_w,
  output logic             out_vld,
  output logic [UID_W-1:0] out_uid,
  output logic [1:0]       out_status,
  output logic [QTY_W-1:0] out_fill_quantity,
  output logic [QTY_W-1:0] out_remain_quantity,
  input  logic             out_rdy,
  output logic             busy
);

  localparam logic [1:0] ST_FULL    = 2'b00;
  localparam logic [1:0] ST_PARTIAL = 2'b01;
  localparam logic [1:0] ST_REJECT  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RSP   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [UID_W-1:0] req_uid_q;
  logic [QTY_W-1:0] req_qty_q;

  // Decision datapath. The comparison is made at ACC_W so that an engine
  // result above 2^QTY_W-1 is never truncated into a smaller value.
  logic [ACC_W-1:0] req_qty_ext;
  logic             a_ge_r;
  logic             a_zero;
  logic [QTY_W-1:0] fill_calc;
  logic [1:0]       status_calc;
  logic             timeout_hit;

  assign req_qty_ext = ACC_W'(req_qty_q);
  assign a_ge_r      = (cnt_rsp_quantity_w >= req_qty_ext);
  assign a_zero      = (cnt_rsp_quantity_w == '0);
  // fill <= request, so the low QTY_W bits hold the whole value when A < R.
  assign fill_calc   = a_ge_r ? req_qty_q : cnt_rsp_quantity_w[QTY_W-1:0];
  assign status_calc = a_ge_r ? ST_FULL : (a_zero ? ST_REJECT : ST_PARTIAL);

`ifdef OB_MK_QTY_CTRL_TIMEOUT_EN
  localparam logic [1:0] ST_TIMEOUT = 2'b11;
  localparam int         TO_W       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TO_W-1:0] to_cnt_q;

  // WAIT is only ever entered from ISSUE, so clearing there is "clear on entry".
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q <= '0;
    end else if (state_q == S_ISSUE) begin
      to_cnt_q <= '0;
    end else if (state_q == S_WAIT && cnt_busy_w) begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

  assign timeout_hit = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Next state and handshake outputs.
  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d     = state_q;
    in_rdy      = 1'b0;
    cnt_cmd_vld = 1'b0;
    out_vld     = 1'b0;
    busy        = 1'b1;
    case (state_q)
      S_IDLE: begin
        in_rdy = 1'b1;
        busy   = 1'b0;
        if (in_vld) begin
          state_d = (in_quantity == '0) ? S_RSP : S_ISSUE;
        end
      end
      S_ISSUE: begin
        // The engine raises busy in this same cycle, so busy is not looked at.
        cnt_cmd_vld = 1'b1;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        if (!cnt_busy_w || timeout_hit) begin
          state_d = S_RSP;
        end
      end
      S_RSP: begin
        out_vld = 1'b1;
        if (out_rdy) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register, request capture and response registers. The response
  // registers are written only when RSP is entered, so they stay stable for
  // as long as out_rdy is held low.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q             <= S_IDLE;
      req_uid_q           <= '0;
      req_qty_q           <= '0;
      out_uid             <= '0;
      out_status          <= '0;
      out_fill_quantity   <= '0;
      out_remain_quantity <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (in_vld) begin
            req_uid_q <= in_uid;
            req_qty_q <= in_quantity;
            if (in_quantity == '0) begin
              out_uid             <= in_uid;
              out_status          <= ST_REJECT;
              out_fill_quantity   <= '0;
              out_remain_quantity <= '0;
            end
          end
        end
        S_WAIT: begin
          if (!cnt_busy_w) begin
            out_uid             <= req_uid_q;
            out_status          <= status_calc;
            out_fill_quantity   <= fill_calc;
            out_remain_quantity <= req_qty_q - fill_calc;
          end
`ifdef OB_MK_QTY_CTRL_TIMEOUT_EN
          else if (timeout_hit) begin
            out_uid             <= req_uid_q;
            out_status          <= ST_TIMEOUT;
            out_fill_quantity   <= '0;
            out_remain_quantity <= req_qty_q;
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ob_mk_qty_ctrl.sv
// tb_ob_mk_qty_ctrl
// Testbench for ob_mk_qty_ctrl: a behavioural count engine with a programmable
// busy time, a table of directed vectors, hand-written reset/stall sequences
// and randomized requests checked against a decision model.
module tb_ob_mk_qty_ctrl;

  localparam int QTY_W = 16;
  localparam int ACC_W = 20;
  localparam int UID_W = 8;
  localparam int TO    = 16;

  localparam logic [1:0] FULL    = 2'b00;
  localparam logic [1:0] PARTIAL = 2'b01;
  localparam logic [1:0] REJECT  = 2'b10;
  localparam logic [1:0] TMO     = 2'b11;

  logic             clk;
  logic             rst;
  logic             in_vld;
  logic [UID_W-1:0] in_uid;
  logic [QTY_W-1:0] in_quantity;
  logic             in_rdy;
  logic             cnt_cmd_vld;
  logic             cnt_busy_w;
  logic [ACC_W-1:0] cnt_rsp_quantity_w;
  logic             out_vld;
  logic [UID_W-1:0] out_uid;
  logic [1:0]       out_status;
  logic [QTY_W-1:0] out_fill_quantity;
  logic [QTY_W-1:0] out_remain_quantity;
  logic             out_rdy;
  logic             busy;

  ob_mk_qty_ctrl #(
    .QTY_W(QTY_W), .ACC_W(ACC_W), .UID_W(UID_W), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .in_vld(in_vld), .in_uid(in_uid), .in_quantity(in_quantity), .in_rdy(in_rdy),
    .cnt_cmd_vld(cnt_cmd_vld), .cnt_busy_w(cnt_busy_w),
    .cnt_rsp_quantity_w(cnt_rsp_quantity_w),
    .out_vld(out_vld), .out_uid(out_uid), .out_status(out_status),
    .out_fill_quantity(out_fill_quantity), .out_remain_quantity(out_remain_quantity),
    .out_rdy(out_rdy), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural engine: busy rises with the command and stays high for
  // eng_lat cycles in total; eng_stuck holds it high forever.
  logic [ACC_W-1:0] eng_a;
  int               eng_lat;
  int               eng_cnt;
  logic             eng_stuck;

  assign cnt_busy_w         = eng_stuck | cnt_cmd_vld | (eng_cnt != 0);
  assign cnt_rsp_quantity_w = eng_a;

  always @(posedge clk) begin
    if (rst)              eng_cnt <= 0;
    else if (cnt_cmd_vld) eng_cnt <= eng_lat - 1;
    else if (eng_cnt != 0) eng_cnt <= eng_cnt - 1;
  end

  // Command monitor.
  int cmd_cnt;
  int cmd_cyc;
  always @(negedge clk) begin
    if (cnt_cmd_vld) begin
      cmd_cnt = cmd_cnt + 1;
      cmd_cyc = cyc;
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Decision model straight from the fill rules.
  task automatic model(input int r, input int a,
                       output logic [1:0] st, output int fill, output int rem);
    if (r == 0) begin
      st = REJECT; fill = 0; rem = 0;
    end else begin
      fill = (a < r) ? a : r;
      rem  = r - fill;
      if (a == 0)      st = REJECT;
      else if (a >= r) st = FULL;
      else             st = PARTIAL;
    end
  endtask

  // One complete transaction with latency, field, stall and release checks.
  task automatic run_txn(input string tag, input logic [7:0] uid, input logic [15:0] r,
                         input logic [19:0] a, input int lat, input int hold,
                         input logic [1:0] st, input logic [15:0] fill,
                         input logic [15:0] rem, input int exp_lat);
    int  acc_cyc;
    int  n;
    int  lat_got;
    bit  stable;
    @(negedge clk);
    eng_a       = a;
    eng_lat     = lat;
    cmd_cnt     = 0;
    out_rdy     = 1'b0;
    in_vld      = 1'b1;
    in_uid      = uid;
    in_quantity = r;
    check({tag, "_in_rdy"}, 32'(in_rdy), 32'd1);
    acc_cyc = cyc;
    @(negedge clk);
    // A second request is held pending while the first is in flight.
    in_uid      = ~uid;
    in_quantity = 16'd7;
    n = 0;
    while (!out_vld && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_out_vld"}, 32'(out_vld), 32'd1);
    lat_got = cyc - acc_cyc;
    if (r == 0) begin
      check({tag, "_lat"}, 32'(lat_got >= 1 && lat_got <= 2), 32'd1);
      check({tag, "_cmd_cnt"}, 32'(cmd_cnt), 32'd0);
    end else begin
      check({tag, "_lat"}, 32'(lat_got), 32'(exp_lat));
      check({tag, "_cmd_cnt"}, 32'(cmd_cnt), 32'd1);
      check({tag, "_cmd_cyc"}, 32'(cmd_cyc - acc_cyc), 32'd1);
    end
    check({tag, "_uid"},    32'(out_uid), 32'(uid));
    check({tag, "_status"}, 32'(out_status), 32'(st));
    check({tag, "_fill"},   32'(out_fill_quantity), 32'(fill));
    check({tag, "_remain"}, 32'(out_remain_quantity), 32'(rem));
    check({tag, "_rsp_flags"}, {29'd0, in_rdy, busy, cnt_cmd_vld}, 32'b010);
    if (hold > 0) begin
      stable = 1'b1;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        if (!out_vld || in_rdy || !busy || out_uid !== uid || out_status !== st ||
            out_fill_quantity !== fill || out_remain_quantity !== rem)
          stable = 1'b0;
      end
      check({tag, "_hold_stable"}, 32'(stable), 32'd1);
    end
    // Handshake cycle: in_vld is still high but must not be taken this cycle.
    out_rdy = 1'b1;
    @(negedge clk);
    out_rdy = 1'b0;
    check({tag, "_release"}, {29'd0, out_vld, in_rdy, busy}, 32'b010);
    in_vld = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  uid;
    logic [15:0] r;
    logic [19:0] a;
    int          lat;
    int          hold;
    logic [1:0]  st;
    logic [15:0] fill;
    logic [15:0] rem;
  } vec_t;

  vec_t vecs[8];

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  m_st;
    int          m_fill;
    int          m_rem;
    logic [15:0] rr;
    logic [19:0] aa;
    int          ll;

    vecs[0] = '{8'h11, 16'd100,   20'd250,     5, 0,  FULL,    16'd100,   16'd0};
    vecs[1] = '{8'h22, 16'd100,   20'd40,      5, 1,  PARTIAL, 16'd40,    16'd60};
    vecs[2] = '{8'h33, 16'd100,   20'd0,       3, 0,  REJECT,  16'd0,     16'd100};
    vecs[3] = '{8'h44, 16'd0,     20'd500,     5, 0,  REJECT,  16'd0,     16'd0};
    vecs[4] = '{8'h55, 16'd65535, 20'hFFFFF,   5, 10, FULL,    16'd65535, 16'd0};
    vecs[5] = '{8'h66, 16'd100,   20'd100,     2, 0,  FULL,    16'd100,   16'd0};
    vecs[6] = '{8'h77, 16'd100,   20'd99,      1, 0,  PARTIAL, 16'd99,    16'd1};
    vecs[7] = '{8'h88, 16'd10,    20'h10005,   4, 0,  FULL,    16'd10,    16'd0};

    rst         = 1'b1;
    in_vld      = 1'b0;
    in_uid      = '0;
    in_quantity = '0;
    out_rdy     = 1'b0;
    eng_a       = '0;
    eng_lat     = 5;
    eng_stuck   = 1'b0;
    cmd_cnt     = 0;
    cmd_cyc     = 0;

    repeat (3) @(negedge clk);
    check("reset_flags", {28'd0, in_rdy, cnt_cmd_vld, out_vld, busy}, 32'b1000);
    check("reset_fields", {6'd0, out_uid, out_status, out_fill_quantity},  32'd0);
    check("reset_remain", 32'(out_remain_quantity), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].uid, vecs[i].r, vecs[i].a, vecs[i].lat,
              vecs[i].hold, vecs[i].st, vecs[i].fill, vecs[i].rem, vecs[i].lat + 2);
    end

    // Reset while waiting on the engine aborts without a response.
    @(negedge clk);
    eng_lat     = 20;
    eng_a       = 20'd300;
    in_vld      = 1'b1;
    in_uid      = 8'h99;
    in_quantity = 16'd500;
    @(negedge clk);
    in_vld = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_wait_busy", {30'd0, busy, out_vld}, 32'b10);
    rst = 1'b1;
    @(negedge clk);
    check("rst_wait_flags", {29'd0, out_vld, in_rdy, busy}, 32'b010);
    check("rst_wait_uid", 32'(out_uid), 32'd0);
    rst = 1'b0;
    run_txn("post_rst", 8'hA5, 16'd1000, 20'd400, 6, 0, PARTIAL, 16'd400, 16'd600, 8);

`ifdef OB_MK_QTY_CTRL_TIMEOUT_EN
    eng_stuck = 1'b1;
    run_txn("timeout", 8'h5A, 16'd321, 20'd999, 3, 2, TMO, 16'd0, 16'd321, TO + 2);
    eng_stuck = 1'b0;
`endif

    for (int i = 0; i < 40; i++) begin
      rr = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
      case ($urandom_range(0, 3))
        0:       aa = '0;
        1:       aa = (rr > 1) ? 20'($urandom_range(1, int'(rr) - 1)) : 20'd0;
        2:       aa = 20'($urandom_range(int'(rr), 20'hFFFFF));
        default: aa = 20'($urandom);
      endcase
      ll = $urandom_range(1, 12);
      model(int'(rr), int'(aa), m_st, m_fill, m_rem);
      run_txn($sformatf("rnd%0d", i), 8'($urandom), rr, aa, ll, $urandom_range(0, 2),
              m_st, 16'(m_fill), 16'(m_rem), ll + 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
